tick_bcd_counter: RTL
=====================

Name: tick_bcd_counter

Overview:
Consumer stage placed directly after the ripple clock divider. Samples the divider's div_clock output in the system clock domain, converts each rising edge into a one-cycle tick, and uses it to advance a DIGITS-wide BCD up-counter under a run/pause/clear control FSM. Its packed BCD output feeds the display logic. All state lives in the single `clock` domain; div_clock is never used as a clock.

Parameters:
DIGITS, 4, number of BCD digits in the counter (1..8)
SYNC_STAGES, 2, flops in the div_clock synchronizer chain (>=2)

Ports:
clock  input  1  system clock; all flops on rising edge
reset  input  1  asynchronous, active-high; clears every flop immediately
div_clock  input  1  slow square wave from the clock divider; asynchronous to `clock`
run  input  1  level; 1 = count, 0 = pause
clear  input  1  synchronous; 1 at an edge zeroes the count and enters IDLE
bcd  output  4*DIGITS  packed count; digit 0 (ones) in bits [3:0]
tick  output  1  registered; 1 for one cycle per detected div_clock rising edge
rollover  output  1  registered; 1 for one cycle when count wraps from all-9s to 0
state  output  2  FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED

Behaviour:
- Reset (asynchronous): sync chain = 0, edge-history flop = 0, bcd = 0, tick = 0, rollover = 0, state = IDLE. Reset asserted mid-count discards the count with no wait for a clock edge.
- Synchronizer: div_clock passes through SYNC_STAGES flops; the last stage is s. A history flop holds p (previous s).
- Edge detect: `rise = s & ~p` (combinational).
- tick output: tick <= rise.
  - A div_clock rising edge sampled at edge k yields tick = 1 after edge k+SYNC_STAGES.
  - Exactly one tick per div_clock rising edge. Falling edges produce no tick.
- FSM (next state is evaluated on the registered state):
  - IDLE: clear -> IDLE; else run=1 -> RUNNING; else stay.
  - RUNNING: clear -> IDLE; else run=0 -> PAUSED; else stay.
  - PAUSED: clear -> IDLE; else run=1 -> RUNNING; else stay.
- Counter update at each edge, in priority order:
  1. clear=1: bcd <= 0, rollover <= 0. Clear wins over a simultaneous rise and over run.
  2. Else, if the registered state is RUNNING and rise=1: increment bcd by 1 in BCD.
  3. Else: hold bcd.
- Increment timing:
  - bcd changes on the same edge that sets tick, so bcd and tick update together.
  - A rise coinciding with the RUNNING->PAUSED transition still increments, because the pre-edge state was RUNNING.
  - A rise coinciding with PAUSED->RUNNING does not increment.
- BCD arithmetic:
  - Digit i increments only if all lower digits are 9. A digit at 9 that receives a carry becomes 0 and carries onward.
  - Digits never hold values above 9.
  - Increment from all-9s (9999 for DIGITS=4) gives 0000, and rollover=1 for that one cycle. Counting continues normally afterward.
- rollover defaults to 0 on every cycle except the wrap cycle.
- tick runs in every state, including IDLE and PAUSED; only counting is gated.
- Only a synchronous clear or a reset zeroes bcd. Entering IDLE from RUNNING or PAUSED happens only via clear.

Test Plan:
- Reset then release, div_clock toggling, run=0 -> bcd=0000 and state=IDLE. tick pulses once per div_clock period. bcd never changes.
- run=1, 12 div_clock rising edges -> state=RUNNING, 12 one-cycle ticks. bcd goes 0000..0012; digit 0 wraps 9->0 with carry on the 10th tick (0009 -> 0010). Each tick appears SYNC_STAGES+1 edges after the asynchronous rise.
- Preload by counting to 9998, then 2 more rises -> 9999, then 0000. rollover=1 exactly on the 0000 cycle and 0 elsewhere.
- Counting at 0042, drop run for 5 div_clock periods, then raise run -> state=PAUSED, bcd holds 0042 while ticks continue. Returns to RUNNING and resumes at 0043.
- clear asserted on the same cycle as rise while RUNNING at 0137 -> bcd=0000, state=IDLE, no increment. tick still pulses that cycle.
- Assert reset asynchronously between clock edges while RUNNING at 0555 -> bcd, tick, rollover and state go to 0 and IDLE immediately. They stay there until reset is released and run is asserted again.

Source files
------------

// File: rtl/tick_bcd_counter.sv
// Synchronizes the divider's div_clock, turns each rising edge into a one-cycle tick,
// and advances a packed BCD up-counter under a run/pause/clear FSM.
module tick_bcd_counter #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  div_clock,
  input  logic                  run,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tick,
  output logic                  rollover,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   hist_p1;
  logic                   rise;

  // Returns {carry_out, incremented value}; carry_out is set only on the all-9s wrap.
  function automatic logic [4*DIGITS:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Stage 0: div_clock synchronizer chain, then edge history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      hist_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], div_clock};
      hist_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign rise = sync_p0[SYNC_STAGES-1] & ~hist_p1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear) state_d = IDLE;    else if (run)  state_d = RUNNING;
      RUNNING: if (clear) state_d = IDLE;    else if (!run) state_d = PAUSED;
      PAUSED:  if (clear) state_d = IDLE;    else if (run)  state_d = RUNNING;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage 1: tick, count and wrap flag all update on the edge that consumes rise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick     <= 1'b0;
      rollover <= 1'b0;
      bcd      <= '0;
    end else begin
      tick     <= rise;
      rollover <= 1'b0;
      if (clear) begin
        bcd <= '0;
      end else if (state_q == RUNNING && rise) begin
        {rollover, bcd} <= bcd_inc(bcd);
      end
    end
  end

  assign state = state_q;

endmodule
